jtopll_wr_ctrl: RTL and testbench
=================================

# jtopll_wr_ctrl

CPU write controller for the OPLL register block. Decodes address/data writes into patch, rhythm and per-channel update commands, and holds each channel command stable for one full slot frame so that the register block's slot match is guaranteed to occur under `cen`. Sits between the CPU bus and `jtopll_reg`, driving its `din`, `sel_group`, `sel_sub`, `up_*`, `rhy_en` and `rhy_kon` inputs.

## Interface
- No parameters.
- `clk` in 1: system clock, single clock domain.
- `rst_n` in 1: synchronous reset, active low.
- `cen` in 1: slot clock enable, shared with the register block.
- `zero` in 1: slot counter frame marker from the register block; qualified by `cen`.
- `wr` in 1: one-`clk` write pulse from the CPU.
- `addr` in 1: 0 selects the index write, 1 selects the data write.
- `din` in 8: CPU write data.
- `dout` out 8: data presented to the register block.
- `sel_group` out 2: target channel group.
- `sel_sub` out 3: target sub-slot, or patch byte index.
- `up_fnumlo`, `up_fnumhi`, `up_inst` out 1 each: channel update levels.
- `up_original` out 1: user patch byte write pulse.
- `rhy_en` out 1: rhythm mode enable.
- `rhy_kon` out 5: rhythm key-on bits.
- `busy` out 1: the pending buffer is full.
- `drop` out 1: one-`clk` pulse when a channel write is discarded.

## Operation
- Index register `idx[7:0]`: `wr & !addr` loads `din`. This takes effect the next cycle.
- Data write (`wr & addr`) is decoded on `idx`:
  - 0x00–0x07: `up_original` pulses for 1 cycle. `sel_sub = idx[2:0]`, `dout = din`. The pulse does not wait for `cen` or the frame. When a channel command is active, the patch write pre-empts the outputs for that single cycle, and the channel command resumes the next cycle with its frame count unaffected.
  - 0x0E: `rhy_en <= din[5]` and `rhy_kon <= din[4:0]`, registered.
  - 0x10–0x18: channel command FNUMLO. 0x20–0x28: FNUMHI. 0x30–0x38: INST. The channel number is `ch = idx[3:0]`, with `sel_group = ch/3` and `sel_sub = ch%3`.
  - All other indices, including 0x0F and channel numbers 9–15: ignored, with no output change.
- Channel command path has two stages, `active` and `pending`. Each stage holds `{type, ch, data}`.
- Active FSM states:
  - IDLE: no channel command outputs.
  - WAIT0: the command is driven, waiting for the first `cen & zero`.
  - FRAME: the command is driven, waiting for the second `cen & zero`.
- Active FSM transitions:
  - IDLE → WAIT0 when a command is loaded.
  - WAIT0 → FRAME on `cen & zero`.
  - FRAME → IDLE on `cen & zero`. If `pending` is full, FRAME → WAIT0 instead, with `pending` moved into `active`.
- While in WAIT0 or FRAME, exactly one of `up_fnumlo`/`up_fnumhi`/`up_inst` is high, and `dout`, `sel_group`, `sel_sub` hold the command values.
- A new channel command:
  - loads `active` if the FSM is IDLE;
  - otherwise fills `pending` if it is empty;
  - otherwise it is discarded and `drop` pulses.
- `busy` equals pending-full.
- In IDLE with no patch pulse, `dout`, `sel_group` and `sel_sub` keep their last values.

## Timing
- Reset values: every output is 0, `idx = 0`, the FSM is IDLE and `pending` is empty.
- Latency: a write in cycle T produces output changes in T+1. This applies to `up_original`, the rhythm registers, `up_*` levels and `drop`.
- Channel level duration: from the first cycle until the cycle after the second `cen & zero`. The second `cen & zero` cycle itself has the level high.
- Simultaneous completion and new write in the same cycle: `pending` moves to `active` and the new write enters `pending`, so there is no drop. If `pending` was empty, the new write goes directly into `active` (WAIT0).
- If `zero` is high in the write cycle T, it does not count toward the frame; counting starts at T+1.
- If `rst_n` goes low mid-command, the command is abandoned and all outputs return to their reset values the next cycle.

## Test plan
- Write idx 0x03, then data 0xA5 → in T+1, `up_original = 1` for 1 cycle, `sel_sub = 3`, `dout = 0xA5`. No `up_*` level.
- Write idx 0x0E, then data 0x3F → `rhy_en = 1`, `rhy_kon = 5'h1F` from T+1. Then write 0x00 → both clear.
- Write idx 0x17, then data 0x55, with `cen` every 2 clk and `zero` every 18 `cen` → `up_fnumlo` stays high across exactly one full frame plus the partial head, with `sel_group = 2`, `sel_sub = 1`, `dout = 0x55`. It falls the cycle after the second `zero`.
- Three back-to-back writes to 0x20, 0x31, 0x32 → the first becomes active and the second pending with `busy = 1`. The third gives `drop = 1` for 1 cycle. The second is issued after the first completes, and the third never appears.
- Write to 0x19 and to 0x0F → no strobe, no level, and `dout`/`sel` unchanged.
- Assert `rst_n = 0` while `up_inst` is high → all outputs are 0 next cycle. After release, the FSM is IDLE and `busy = 0`.

Source files
------------

// File: rtl/jtopll_wr_ctrl.sv
// CPU write controller for the OPLL register block: decodes index/data writes into
// patch, rhythm and channel update commands, holding each channel command for a full slot frame.
module jtopll_wr_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       zero,
    input  logic       wr,
    input  logic       addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic [1:0] sel_group,
    output logic [2:0] sel_sub,
    output logic       up_fnumlo,
    output logic       up_fnumhi,
    output logic       up_inst,
    output logic       up_original,
    output logic       rhy_en,
    output logic [4:0] rhy_kon,
    output logic       busy,
    output logic       drop
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT0 = 2'd1,
        FRAME = 2'd2
    } state_t;

    // kind: 1 = FNUMLO, 2 = FNUMHI, 3 = INST
    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] ch;
        logic [7:0] data;
    } cmd_t;

    function automatic logic [1:0] ch_group(input logic [3:0] ch);
        logic [1:0] g;
        case (ch)
            4'd0, 4'd1, 4'd2: g = 2'd0;
            4'd3, 4'd4, 4'd5: g = 2'd1;
            default:          g = 2'd2;
        endcase
        return g;
    endfunction

    function automatic logic [2:0] ch_sub(input logic [3:0] ch);
        logic [2:0] s;
        case (ch)
            4'd0, 4'd3, 4'd6: s = 3'd0;
            4'd1, 4'd4, 4'd7: s = 3'd1;
            default:          s = 3'd2;
        endcase
        return s;
    endfunction

    logic [7:0] idx_reg;
    state_t     state_reg, state_next;
    cmd_t       act_reg, act_next;
    cmd_t       pend_reg, pend_next;
    logic       pend_valid_reg, pend_valid_next;
    logic       drop_next;

    logic       data_wr;
    logic       patch_wr;
    logic       rhy_wr;
    logic       chan_wr;
    logic [1:0] chan_kind;
    logic       frame_tick;
    cmd_t       new_cmd;

    always_comb begin
        data_wr    = wr & addr;
        patch_wr   = data_wr && (idx_reg[7:3] == 5'd0);
        rhy_wr     = data_wr && (idx_reg == 8'h0E);
        case (idx_reg[7:4])
            4'h1:    chan_kind = 2'd1;
            4'h2:    chan_kind = 2'd2;
            4'h3:    chan_kind = 2'd3;
            default: chan_kind = 2'd0;
        endcase
        chan_wr    = data_wr && (chan_kind != 2'd0) && (idx_reg[3:0] <= 4'd8);
        frame_tick = cen & zero;
        new_cmd    = '{kind: chan_kind, ch: idx_reg[3:0], data: din};
    end

    // Two-stage command path: active is driven until two frame markers pass,
    // pending waits behind it; a third command arriving while both are full is lost.
    always_comb begin
        state_next      = state_reg;
        act_next        = act_reg;
        pend_next       = pend_reg;
        pend_valid_next = pend_valid_reg;
        drop_next       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (chan_wr) begin
                    act_next   = new_cmd;
                    state_next = WAIT0;
                end
            end
            WAIT0: begin
                if (frame_tick) begin
                    state_next = FRAME;
                end
                if (chan_wr) begin
                    if (!pend_valid_reg) begin
                        pend_next       = new_cmd;
                        pend_valid_next = 1'b1;
                    end else begin
                        drop_next = 1'b1;
                    end
                end
            end
            FRAME: begin
                if (frame_tick) begin
                    if (pend_valid_reg) begin
                        act_next   = pend_reg;
                        state_next = WAIT0;
                        if (chan_wr) begin
                            pend_next = new_cmd;
                        end else begin
                            pend_valid_next = 1'b0;
                        end
                    end else if (chan_wr) begin
                        act_next   = new_cmd;
                        state_next = WAIT0;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (chan_wr) begin
                    if (!pend_valid_reg) begin
                        pend_next       = new_cmd;
                        pend_valid_next = 1'b1;
                    end else begin
                        drop_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_reg        <= 8'd0;
            state_reg      <= IDLE;
            act_reg        <= '0;
            pend_reg       <= '0;
            pend_valid_reg <= 1'b0;
            dout           <= 8'd0;
            sel_group      <= 2'd0;
            sel_sub        <= 3'd0;
            up_fnumlo      <= 1'b0;
            up_fnumhi      <= 1'b0;
            up_inst        <= 1'b0;
            up_original    <= 1'b0;
            rhy_en         <= 1'b0;
            rhy_kon        <= 5'd0;
            busy           <= 1'b0;
            drop           <= 1'b0;
        end else begin
            if (wr && !addr) begin
                idx_reg <= din;
            end
            state_reg      <= state_next;
            act_reg        <= act_next;
            pend_reg       <= pend_next;
            pend_valid_reg <= pend_valid_next;
            busy           <= pend_valid_next;
            drop           <= drop_next;
            up_original    <= patch_wr;

            if (rhy_wr) begin
                rhy_en  <= din[5];
                rhy_kon <= din[4:0];
            end

            // A patch byte borrows the bus for one cycle; the channel FSM keeps counting.
            if (patch_wr) begin
                dout      <= din;
                sel_sub   <= idx_reg[2:0];
                up_fnumlo <= 1'b0;
                up_fnumhi <= 1'b0;
                up_inst   <= 1'b0;
            end else if (state_next != IDLE) begin
                dout      <= act_next.data;
                sel_group <= ch_group(act_next.ch);
                sel_sub   <= ch_sub(act_next.ch);
                up_fnumlo <= (act_next.kind == 2'd1);
                up_fnumhi <= (act_next.kind == 2'd2);
                up_inst   <= (act_next.kind == 2'd3);
            end else begin
                up_fnumlo <= 1'b0;
                up_fnumhi <= 1'b0;
                up_inst   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtopll_wr_ctrl.sv
// Directed bench for jtopll_wr_ctrl: expected patch strobes and channel commands are queued
// when written and compared when the controller presents them.
module tb_jtopll_wr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic       zero = 1'b0;
    logic       wr = 1'b0;
    logic       addr = 1'b0;
    logic [7:0] din = 8'd0;
    logic [7:0] dout;
    logic [1:0] sel_group;
    logic [2:0] sel_sub;
    logic       up_fnumlo, up_fnumhi, up_inst, up_original;
    logic       rhy_en;
    logic [4:0] rhy_kon;
    logic       busy, drop;

    jtopll_wr_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .zero       (zero),
        .wr         (wr),
        .addr       (addr),
        .din        (din),
        .dout       (dout),
        .sel_group  (sel_group),
        .sel_sub    (sel_sub),
        .up_fnumlo  (up_fnumlo),
        .up_fnumhi  (up_fnumhi),
        .up_inst    (up_inst),
        .up_original(up_original),
        .rhy_en     (rhy_en),
        .rhy_kon    (rhy_kon),
        .busy       (busy),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] data;
        logic [1:0] grp;
        logic [2:0] sub;
    } exp_t;

    exp_t pq[$];
    exp_t cq[$];
    exp_t cur;

    int n_assert = 0;
    int n_fail   = 0;
    bit gen_on   = 1'b0;
    bit mon_on   = 1'b0;
    int cen_ph   = 0;
    int cen_n    = 0;
    bit in_cmd   = 1'b0;
    bit after_pre = 1'b0;
    int zc       = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic       lv;
        logic [1:0] k;
        exp_t       e;
        if (!mon_on) begin
            in_cmd    = 1'b0;
            zc        = 0;
            after_pre = 1'b0;
            return;
        end
        lv = up_fnumlo | up_fnumhi | up_inst;
        k  = up_inst ? 2'd3 : (up_fnumhi ? 2'd2 : (up_fnumlo ? 2'd1 : 2'd0));
        if (up_original) begin
            check("patch_preempts_level", {31'd0, lv}, 32'd0);
            check("patch_expected", {31'd0, pq.size() > 0}, 32'd1);
            if (pq.size() > 0) begin
                e = pq.pop_front();
                check("patch_dout", {24'd0, dout}, {24'd0, e.data});
                check("patch_sub", {29'd0, sel_sub}, {29'd0, e.sub});
                $display("patch  dout=%02h sub=%0d", dout, sel_sub);
            end
            after_pre = in_cmd;
        end else if (lv) begin
            check("level_onehot", $countones({up_fnumlo, up_fnumhi, up_inst}), 32'd1);
            if (!in_cmd || zc == 2) begin
                check("cmd_expected", {31'd0, cq.size() > 0}, 32'd1);
                if (cq.size() > 0) begin
                    cur = cq.pop_front();
                    check("cmd_kind", {30'd0, k}, {30'd0, cur.kind});
                    check("cmd_dout", {24'd0, dout}, {24'd0, cur.data});
                    check("cmd_group", {30'd0, sel_group}, {30'd0, cur.grp});
                    check("cmd_sub", {29'd0, sel_sub}, {29'd0, cur.sub});
                    $display("cmd    kind=%0d dout=%02h grp=%0d sub=%0d", k, dout, sel_group, sel_sub);
                end
                in_cmd = 1'b1;
                zc     = 0;
            end else if (after_pre) begin
                check("resume_kind", {30'd0, k}, {30'd0, cur.kind});
                check("resume_dout", {24'd0, dout}, {24'd0, cur.data});
                check("resume_group", {30'd0, sel_group}, {30'd0, cur.grp});
                check("resume_sub", {29'd0, sel_sub}, {29'd0, cur.sub});
            end
            after_pre = 1'b0;
        end else begin
            if (in_cmd) begin
                check("level_frames", zc, 32'd2);
                $display("cmd    ended after %0d frame markers", zc);
            end
            in_cmd    = 1'b0;
            after_pre = 1'b0;
        end
        if (in_cmd && cen && zero) zc++;
    endtask

    // cen every second clk, zero on every 18th cen
    task automatic cycle();
        @(posedge clk);
        #1;
        if (gen_on) begin
            cen_ph ^= 1;
            cen = (cen_ph == 0);
            if (cen) begin
                zero  = (cen_n == 17);
                cen_n = (cen_n + 1) % 18;
            end else begin
                zero = 1'b0;
            end
        end else begin
            cen  = 1'b0;
            zero = 1'b0;
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic wr_cycle(input logic a, input logic [7:0] d);
        wr   = 1'b1;
        addr = a;
        din  = d;
        cycle();
        wr   = 1'b0;
        addr = 1'b0;
    endtask

    task automatic patch(input logic [7:0] i, input logic [7:0] d);
        exp_t e;
        logic [7:0] iv;
        iv = i;
        e.kind = 2'd0;
        e.data = d;
        e.grp  = 2'd0;
        e.sub  = iv[2:0];
        wr_cycle(1'b0, i);
        pq.push_back(e);
        wr_cycle(1'b1, d);
    endtask

    task automatic chan(input logic [7:0] i, input logic [7:0] d, input bit expect_drop);
        exp_t e;
        logic [7:0] iv;
        int ch;
        iv = i;
        ch = int'(iv[3:0]);
        e.kind = iv[5:4];
        e.data = d;
        e.grp  = 2'(ch / 3);
        e.sub  = 3'(ch % 3);
        wr_cycle(1'b0, i);
        if (!expect_drop) cq.push_back(e);
        wr_cycle(1'b1, d);
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cycle();
            if (cq.size() == 0 && pq.size() == 0 && !in_cmd) begin
                ok = 1'b1;
                break;
            end
        end
        check({"drain_", tag}, {31'd0, ok}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {7'd0, dout, sel_group, sel_sub, up_fnumlo, up_fnumhi, up_inst,
                    up_original, rhy_en, rhy_kon, busy, drop}, 32'd0);
    endtask

    initial begin
        repeat (3) cycle();
        check_reset_outputs("reset_outputs");
        rst_n = 1'b1;
        cycle();
        mon_on = 1'b1;

        // patch byte, single-cycle strobe
        patch(8'h03, 8'hA5);
        cycle();
        check("patch_once", {31'd0, up_original}, 32'd0);

        // rhythm register
        wr_cycle(1'b0, 8'h0E);
        wr_cycle(1'b1, 8'h3F);
        check("rhy_en_set", {31'd0, rhy_en}, 32'd1);
        check("rhy_kon_set", {27'd0, rhy_kon}, 32'h1F);
        $display("rhy    en=%0d kon=%02h", rhy_en, rhy_kon);
        wr_cycle(1'b1, 8'h00);
        check("rhy_en_clr", {31'd0, rhy_en}, 32'd0);
        check("rhy_kon_clr", {27'd0, rhy_kon}, 32'd0);
        $display("rhy    en=%0d kon=%02h", rhy_en, rhy_kon);

        // one FNUMLO command across a frame, with a patch write pre-empting it briefly
        gen_on = 1'b1;
        chan(8'h17, 8'h55, 1'b0);
        repeat (4) cycle();
        patch(8'h05, 8'h3C);
        wait_done("frame");

        // active + pending + dropped
        chan(8'h20, 8'h11, 1'b0);
        chan(8'h31, 8'h22, 1'b0);
        check("busy_pending", {31'd0, busy}, 32'd1);
        chan(8'h32, 8'h33, 1'b1);
        check("drop_pulse", {31'd0, drop}, 32'd1);
        $display("drop   drop=%0d busy=%0d", drop, busy);
        cycle();
        check("drop_once", {31'd0, drop}, 32'd0);
        check("busy_held", {31'd0, busy}, 32'd1);
        wait_done("queue");
        check("busy_clear", {31'd0, busy}, 32'd0);

        // ignored indices leave the bus alone
        wr_cycle(1'b0, 8'h19);
        wr_cycle(1'b1, 8'h77);
        wr_cycle(1'b0, 8'h0F);
        wr_cycle(1'b1, 8'h88);
        cycle();
        check("ignored_dout", {24'd0, dout}, 32'h22);
        check("ignored_group", {30'd0, sel_group}, 32'd0);
        check("ignored_sub", {29'd0, sel_sub}, 32'd1);
        check("ignored_rhy", {26'd0, rhy_en, rhy_kon}, 32'd0);
        check("ignored_drop", {30'd0, drop, busy}, 32'd0);
        $display("ignore dout=%02h grp=%0d sub=%0d", dout, sel_group, sel_sub);

        // reset in the middle of an INST command
        chan(8'h30, 8'h99, 1'b0);
        repeat (3) cycle();
        check("inst_high", {31'd0, up_inst}, 32'd1);
        mon_on = 1'b0;
        rst_n  = 1'b0;
        cycle();
        check_reset_outputs("midcmd_reset_outputs");
        $display("reset  outputs cleared dout=%02h up_inst=%0d", dout, up_inst);
        rst_n = 1'b1;
        cq.delete();
        pq.delete();
        cycle();
        check("post_reset_busy", {31'd0, busy}, 32'd0);
        check("post_reset_level", {29'd0, up_fnumlo, up_fnumhi, up_inst}, 32'd0);
        mon_on = 1'b1;
        cycle();
        chan(8'h25, 8'h4C, 1'b0);
        wait_done("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
